// File: rtl/traffic_phase_ctrl.sv
// Two-way traffic-light sequencer: 1 s prescaler, six-phase FSM with per-phase
// countdown, manual adjust, pause and pedestrian shortening of green phases.
module traffic_phase_ctrl #(
    parameter int TICK_DIV = 16000000,
    parameter int G_PERIOD = 20,
    parameter int Y_PERIOD = 3,
    parameter int R_PERIOD = 1,
    parameter int PED_MIN  = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pause_i,
    input  logic       btn_up_i,
    input  logic       btn_dn_i,
    input  logic       ped_req_i,
    output logic [2:0] ns_lamp_o,
    output logic [2:0] ew_lamp_o,
    output logic [2:0] phase_o,
    output logic [6:0] remain_o,
    output logic [3:0] bcd_tens_o,
    output logic [3:0] bcd_ones_o,
    output logic       tick_o,
    output logic       ped_ack_o
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        RED1 = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        RED2 = 3'd5
    } phase_e;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    phase_e          phase_q, phase_d, nxt_phase;
    logic [6:0]      remain_q, remain_d, nxt_len;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_q, tick_d;
    logic            pend_q, pend_d;
    logic            ack_q, ack_d;
    logic            serve;
    logic [3:0]      tens;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= NS_G;
            remain_q <= 7'(G_PERIOD);
            presc_q  <= '0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        nxt_phase = NS_G;
        nxt_len   = 7'(G_PERIOD);
        case (phase_q)
            NS_G:    begin nxt_phase = NS_Y; nxt_len = 7'(Y_PERIOD); end
            NS_Y:    begin nxt_phase = RED1; nxt_len = 7'(R_PERIOD); end
            RED1:    begin nxt_phase = EW_G; nxt_len = 7'(G_PERIOD); end
            EW_G:    begin nxt_phase = EW_Y; nxt_len = 7'(Y_PERIOD); end
            EW_Y:    begin nxt_phase = RED2; nxt_len = 7'(R_PERIOD); end
            default: begin nxt_phase = NS_G; nxt_len = 7'(G_PERIOD); end
        endcase
    end

    // Priority on remain: illegal-state recovery, tick, manual adjust, ped serve.
    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        pend_d   = pend_q;

        if (!pause_i) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        serve = pend_q && (phase_q == NS_G || phase_q == EW_G) &&
                (remain_q > 7'(PED_MIN)) && !tick_q && !btn_up_i && !btn_dn_i;

        if (phase_q > RED2) begin
            phase_d  = NS_G;
            remain_d = 7'(G_PERIOD);
        end else if (tick_q) begin
            if (remain_q > 7'd1) begin
                remain_d = remain_q - 7'd1;
            end else begin
                phase_d  = nxt_phase;
                remain_d = nxt_len;
            end
        end else if (btn_up_i && !btn_dn_i) begin
            if (remain_q < 7'd99) remain_d = remain_q + 7'd1;
        end else if (btn_dn_i && !btn_up_i) begin
            if (remain_q > 7'd1) remain_d = remain_q - 7'd1;
        end else if (serve) begin
            remain_d = 7'(PED_MIN);
        end

        // A request landing on a serve cycle is absorbed by it.
        if (serve)          pend_d = 1'b0;
        else if (ped_req_i) pend_d = 1'b1;
        ack_d = serve;
    end

    always_comb begin
        ns_lamp_o = LAMP_R;
        ew_lamp_o = LAMP_R;
        case (phase_q)
            NS_G:    ns_lamp_o = LAMP_G;
            NS_Y:    ns_lamp_o = LAMP_Y;
            EW_G:    ew_lamp_o = LAMP_G;
            EW_Y:    ew_lamp_o = LAMP_Y;
            default: ;
        endcase
    end

    always_comb begin
        tens = 4'd0;
        for (int t = 1; t <= 9; t++) begin
            if (remain_q >= 7'(10 * t)) tens = 4'(t);
        end
        bcd_tens_o = tens;
        bcd_ones_o = 4'(remain_q - 7'(tens) * 7'd10);
    end

    assign phase_o   = phase_q;
    assign remain_o  = remain_q;
    assign tick_o    = tick_q;
    assign ped_ack_o = ack_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with TICK_DIV=4 and default periods.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_lamp, ew_lamp, phase;
    logic [6:0] remain;
    logic [3:0] bcd_tens, bcd_ones;
    logic       tick, ped_ack;

    int n_asrt = 0;
    int n_fail = 0;
    int exp_ph = 0;
    int exp_rem = 20;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(.TICK_DIV(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pause_i    (pause),
        .btn_up_i   (btn_up),
        .btn_dn_i   (btn_dn),
        .ped_req_i  (ped_req),
        .ns_lamp_o  (ns_lamp),
        .ew_lamp_o  (ew_lamp),
        .phase_o    (phase),
        .remain_o   (remain),
        .bcd_tens_o (bcd_tens),
        .bcd_ones_o (bcd_ones),
        .tick_o     (tick),
        .ped_ack_o  (ped_ack)
    );

    function automatic int plen(int p);
        case (p)
            0, 3:    return 20;
            1, 4:    return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int ns_exp(int p);
        case (p)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int ew_exp(int p);
        case (p)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles stepped until tick is seen, -1 on timeout.
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        while (tick !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'(exp_ph));
        chk({tag, "_remain"}, 32'(remain), 32'(exp_rem));
        chk({tag, "_ns"}, 32'(ns_lamp), 32'(ns_exp(exp_ph)));
        chk({tag, "_ew"}, 32'(ew_lamp), 32'(ew_exp(exp_ph)));
        chk({tag, "_tens"}, 32'(bcd_tens), 32'(exp_rem / 10));
        chk({tag, "_ones"}, 32'(bcd_ones), 32'(exp_rem % 10));
    endtask

    // One elapsed second: wait for tick, let the countdown apply, compare to model.
    task automatic run_sec(input int exp_n);
        int n;
        wait_tick(8, n);
        chk("tick_seen", 32'(n >= 0), 32'd1);
        if (exp_n > 0) chk("tick_period", 32'(n), 32'(exp_n));
        step();
        if (exp_rem > 1) exp_rem--;
        else begin
            exp_ph  = (exp_ph + 1) % 6;
            exp_rem = plen(exp_ph);
        end
        chk_state("sec");
    endtask

    initial begin
        int n;
        int seen;
        int acks;

        repeat (3) step();
        chk_state("reset");
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_ack", 32'(ped_ack), 32'd0);

        // Full phase cycle, 48 seconds, back to NS_G with 20.
        rst = 1'b0;
        run_sec(4);
        repeat (47) run_sec(3);
        chk("cycle_back_ph", 32'(phase), 32'd0);
        chk("cycle_back_rem", 32'(remain), 32'd20);

        // Pause at remain=12.
        repeat (8) run_sec(3);
        chk("pre_pause_rem", 32'(remain), 32'd12);
        pause = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tick !== 1'b0) seen++;
        end
        chk("pause_no_tick", 32'(seen), 32'd0);
        chk("pause_hold_rem", 32'(remain), 32'd12);
        pause = 1'b0;
        wait_tick(4, n);
        chk("resume_tick_lat", 32'(n), 32'd3);
        step();
        exp_rem = 11;
        chk_state("resume");

        // Manual adjust while paused.
        pause = 1'b1;
        btn_up = 1'b1;
        repeat (87) step();
        chk("up_to_98", 32'(remain), 32'd98);
        repeat (3) step();
        chk("up_sat_99", 32'(remain), 32'd99);
        btn_up = 1'b0;
        btn_dn = 1'b1;
        repeat (97) step();
        chk("dn_to_2", 32'(remain), 32'd2);
        repeat (3) step();
        chk("dn_sat_1", 32'(remain), 32'd1);
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        chk("both_ignored", 32'(remain), 32'd1);
        btn_up = 1'b1;
        repeat (4) step();
        btn_up = 1'b0;
        chk("up_to_5", 32'(remain), 32'd5);

        // btn_up in the tick cycle is dropped; only the decrement applies.
        pause = 1'b0;
        wait_tick(4, n);
        chk("adj_tick_seen", 32'(n), 32'd3);
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        exp_ph = 0;
        exp_rem = 4;
        chk_state("up_on_tick");

        // Request during NS_Y waits for EW_G start.
        while (exp_ph != 1) run_sec(0);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("nsy_no_ack", 32'(ped_ack), 32'd0);
        while (exp_ph != 3) run_sec(0);
        chk("ewg_load_20", 32'(remain), 32'd20);
        step();
        chk("ewg_served_rem", 32'(remain), 32'd5);
        chk("ewg_ack", 32'(ped_ack), 32'd1);
        step();
        chk("ewg_ack_1cyc", 32'(ped_ack), 32'd0);
        exp_rem = 5;

        // Request at remain=PED_MIN stays pending until the next NS_G.
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("min_no_ack", 32'(ped_ack), 32'd0);
        while (exp_ph != 0) run_sec(0);
        step();
        chk("nsg_served_rem", 32'(remain), 32'd5);
        chk("nsg_ack", 32'(ped_ack), 32'd1);
        step();
        chk("nsg_ack_1cyc", 32'(ped_ack), 32'd0);
        exp_rem = 5;

        // Mid-green request at remain=15.
        while (!(exp_ph == 3 && exp_rem == 15)) run_sec(0);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 0;
        while (ped_ack !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        chk("mid_ack_seen", 32'(ped_ack), 32'd1);
        chk("mid_rem_5", 32'(remain), 32'd5);
        step();
        chk("mid_ack_1cyc", 32'(ped_ack), 32'd0);
        exp_rem = 5;

        // Reset in EW_Y while paused with a request pending.
        while (exp_ph != 4) run_sec(0);
        pause = 1'b1;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        rst = 1'b1;
        step();
        exp_ph = 0;
        exp_rem = 20;
        chk_state("midrst");
        chk("midrst_tick", 32'(tick), 32'd0);
        chk("midrst_ack", 32'(ped_ack), 32'd0);
        rst = 1'b0;
        pause = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ped_ack !== 1'b0) acks++;
        end
        chk("post_rst_no_ack", 32'(acks), 32'd0);
        chk("post_rst_rem", 32'(remain), 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
